// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - op codes, divider handshake levels and DivCtl state encoding
package div_issue_ctrl_pkg;

    localparam logic [7:0] EXE_NOP_OP     = 8'b0000_0000;
    localparam logic [7:0] EXE_DIV_OP     = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP    = 8'b0001_1011;

    localparam logic       DivStart       = 1'b1;
    localparam logic       DivStop        = 1'b0;
    localparam logic       DivResultReady = 1'b1;

    typedef enum logic [1:0] {
        DIVCTL_IDLE  = 2'b00,
        DIVCTL_BUSY  = 2'b01,
        DIVCTL_DONE  = 2'b10,
        DIVCTL_ABORT = 2'b11
    } divctl_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - architectural HI/LO pair with prioritized divider and WB write ports
module hilo_reg (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_div_we,
    input  logic [31:0] i_div_hi,
    input  logic [31:0] i_div_lo,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_hi,
    input  logic [31:0] i_wb_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Divider capture wins over WB: the divide in EX is younger than the MTHI/MTLO in WB
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi <= 32'h0;
            r_lo <= 32'h0;
        end else if (i_div_we) begin
            r_hi <= i_div_hi;
            r_lo <= i_div_lo;
        end else if (i_wb_we) begin
            r_hi <= i_wb_hi;
            r_lo <= i_wb_lo;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage issue/stall/commit controller for the iterative divider
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  op_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        whilo_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [7:0]  div_op_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    divctl_state_e r_state;
    divctl_state_e w_next_state;
    logic          r_ab_cnt;
    logic          w_ab_cnt_next;
    logic          w_is_div;
    logic          w_ready;
    logic          w_start;
    logic          w_annul;
    logic          w_stallreq;
    logic          w_capture;

    assign w_is_div = is_div_op(op_i);
    assign w_ready  = (div_ready_i == DivResultReady);

    // State and abort-drain counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= DIVCTL_IDLE;
            r_ab_cnt <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_ab_cnt <= w_ab_cnt_next;
        end
    end

    // Next state plus divider handshake, stall request and capture strobe
    always_comb begin
        w_next_state  = r_state;
        w_ab_cnt_next = 1'b0;
        w_start       = DivStop;
        w_annul       = 1'b0;
        w_stallreq    = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            DIVCTL_IDLE: begin
                if (w_is_div && !flush_i) begin
                    w_start      = DivStart;
                    w_stallreq   = 1'b1;
                    w_next_state = DIVCTL_BUSY;
                end
            end
            DIVCTL_BUSY: begin
                // Dropping start in the ready cycle lets the divider free itself for a following divide
                w_start    = w_ready ? DivStop : DivStart;
                w_stallreq = !w_ready;
                if (flush_i) begin
                    w_next_state = DIVCTL_ABORT;
                end else if (w_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = stall_i ? DIVCTL_DONE : DIVCTL_IDLE;
                end
            end
            DIVCTL_DONE: begin
                // Result already committed; wait for EX to advance without re-issuing
                if (flush_i) begin
                    w_next_state = DIVCTL_ABORT;
                end else if (!stall_i) begin
                    w_next_state = DIVCTL_IDLE;
                end
            end
            DIVCTL_ABORT: begin
                // Two annul cycles let the divider drain back to its free state
                w_annul       = 1'b1;
                w_stallreq    = w_is_div;
                w_ab_cnt_next = ~r_ab_cnt;
                if (r_ab_cnt) begin
                    w_next_state = DIVCTL_IDLE;
                end
            end
            default: begin
                w_next_state = DIVCTL_IDLE;
            end
        endcase
    end

    assign div_op_o      = op_i;
    assign div_opdata1_o = reg1_i;
    assign div_opdata2_o = reg2_i;
    assign div_start_o   = w_start & rst;
    assign div_annul_o   = w_annul & rst;
    assign stallreq_o    = w_stallreq & rst;

    hilo_reg u_hilo_reg (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_div_we (w_capture),
        .i_div_hi (div_result_i[63:32]),
        .i_div_lo (div_result_i[31:0]),
        .i_wb_we  (whilo_i),
        .i_wb_hi  (hi_i),
        .i_wb_lo  (lo_i),
        .o_hi     (hi_o),
        .o_lo     (lo_o)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl with a behavioural divider
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  op_i;
    logic [31:0] reg1_i, reg2_i;
    logic        flush_i, stall_i, whilo_i;
    logic [31:0] hi_i, lo_i;
    logic [7:0]  div_op_o;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        div_start_o, div_annul_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stallreq_o;
    logic [31:0] hi_o, lo_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .op_i          (op_i),
        .reg1_i        (reg1_i),
        .reg2_i        (reg2_i),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .whilo_i       (whilo_i),
        .hi_i          (hi_i),
        .lo_i          (lo_i),
        .div_op_o      (div_op_o),
        .div_opdata1_o (div_opdata1_o),
        .div_opdata2_o (div_opdata2_o),
        .div_start_o   (div_start_o),
        .div_annul_o   (div_annul_o),
        .div_result_i  (div_result_i),
        .div_ready_i   (div_ready_i),
        .stallreq_o    (stallreq_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    // Behavioural divider: {remainder, quotient}, zero for a zero divisor
    function automatic logic [63:0] div_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'h0) begin
            q = 32'h0; r = 32'h0;
        end else if (op == EXE_DIV_OP) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    logic [1:0]  d_st;
    int          d_cnt;
    logic [63:0] d_res;

    // Divider timing: ready set 34 edges after start (2 for a zero divisor), freed when start drops
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_st <= 2'd0; d_cnt <= 0; d_res <= '0;
            div_ready_i <= 1'b0; div_result_i <= '0;
        end else begin
            case (d_st)
                2'd0: if (div_start_o && !div_annul_o) begin
                    d_st  <= 2'd1;
                    d_cnt <= (div_opdata2_o == 32'h0) ? 2 : 34;
                    d_res <= div_ref(div_op_o, div_opdata1_o, div_opdata2_o);
                end
                2'd1: if (div_annul_o) d_st <= 2'd0;
                      else if (d_cnt == 1) begin
                          d_st <= 2'd2; div_ready_i <= 1'b1; div_result_i <= d_res;
                      end else d_cnt <= d_cnt - 1;
                default: if (!div_start_o) begin
                    d_st <= 2'd0; div_ready_i <= 1'b0; div_result_i <= '0;
                end
            endcase
        end
    end

    // Issue a divide at posedge+1, count stall cycles, check capture against the scoreboard
    task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int exp_stall, input bit wb, input bit keep);
        int n;
        logic [63:0] exp;
        op_i = op; reg1_i = a; reg2_i = b;
        n = 0;
        @(negedge clk);
        n_checks++;
        if (div_start_o !== 1'b1) begin
            n_fail++; $display("FAIL %s start_cycle0: got %b want 1", name, div_start_o);
        end
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            if (wb && n == exp_stall) begin
                whilo_i = 1'b1; hi_i = 32'hAAAA_0000; lo_i = 32'h0000_5555;
            end
            @(negedge clk);
        end
        n_checks++;
        if (n !== exp_stall) begin
            n_fail++; $display("FAIL %s stall_len: got %0d want %0d", name, n, exp_stall);
        end
        n_checks++;
        if (div_start_o !== 1'b0) begin
            n_fail++; $display("FAIL %s start_in_ready_cycle: got %b want 0", name, div_start_o);
        end
        @(posedge clk); #1;
        whilo_i = 1'b0;
        if (!keep) op_i = EXE_NOP_OP;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL %s scoreboard: got empty queue want entry", name);
        end else begin
            exp = exp_q.pop_front();
            if ({hi_o, lo_o} !== exp) begin
                n_fail++; $display("FAIL %s hilo: got %h_%h want %h_%h", name, hi_o, lo_o, exp[63:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; op_i = EXE_DIVU_OP; reg1_i = 32'd100; reg2_i = 32'd7;
        flush_i = 0; stall_i = 0; whilo_i = 0; hi_i = 0; lo_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({div_start_o, div_annul_o, stallreq_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000", {div_start_o, div_annul_o, stallreq_o});
        end
        n_checks++;
        if ({hi_o, lo_o} !== 64'h0) begin
            n_fail++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi_o, lo_o);
        end
        n_checks++;
        if (div_op_o !== EXE_DIVU_OP || div_opdata1_o !== 32'd100 || div_opdata2_o !== 32'd7) begin
            n_fail++; $display("FAIL passthrough: got %h %h %h want 1b 64 7", div_op_o, div_opdata1_o, div_opdata2_o);
        end
        @(posedge clk); #1;
        op_i = EXE_NOP_OP; rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_divu();
        exp_q.push_back({32'd2, 32'd14});
        run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 35, 0, 0);
    endtask

    task automatic test_div_zero();
        exp_q.push_back(64'h0);
        run_div("div_5_0", EXE_DIV_OP, 32'd5, 32'd0, 3, 0, 0);
    endtask

    task automatic test_signed();
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 35, 0, 0);
        exp_q.push_back({32'h1, 32'hFFFF_FFFD});
        run_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 35, 0, 0);
    endtask

    task automatic test_flush();
        op_i = EXE_DIVU_OP; reg1_i = 32'd100; reg2_i = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; reg1_i = 32'd9; reg2_i = 32'd3;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({div_annul_o, div_start_o, stallreq_o} !== 3'b101) begin
                n_fail++; $display("FAIL flush_abort_cyc%0d: got annul,start,stall=%b want 101", k,
                                   {div_annul_o, div_start_o, stallreq_o});
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({hi_o, lo_o} !== {32'h1, 32'hFFFF_FFFD}) begin
            n_fail++; $display("FAIL flush_hilo_kept: got %h_%h want 00000001_fffffffd", hi_o, lo_o);
        end
        exp_q.push_back({32'd0, 32'd3});
        run_div("divu_9_3_after_flush", EXE_DIVU_OP, 32'd9, 32'd3, 35, 0, 0);
    endtask

    task automatic test_flush_at_ready();
        op_i = EXE_DIVU_OP; reg1_i = 32'd50; reg2_i = 32'd5;
        repeat (35) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; op_i = EXE_NOP_OP;
        n_checks++;
        if ({hi_o, lo_o} !== {32'd0, 32'd3}) begin
            n_fail++; $display("FAIL flush_ready_discard: got %h_%h want 0_3", hi_o, lo_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (div_annul_o !== (k < 2)) begin
                n_fail++; $display("FAIL flush_ready_annul_cyc%0d: got %b want %b", k, div_annul_o, k < 2);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_done();
        stall_i = 1'b1;
        exp_q.push_back({32'd2, 32'd3});
        run_div("divu_20_6_stalled", EXE_DIVU_OP, 32'd20, 32'd6, 35, 0, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({div_start_o, stallreq_o, div_annul_o} !== 3'b000) begin
                n_fail++; $display("FAIL done_hold_cyc%0d: got start,stall,annul=%b want 000", k,
                                   {div_start_o, stallreq_o, div_annul_o});
            end
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (div_start_o !== 1'b0) begin
            n_fail++; $display("FAIL done_release_start: got %b want 0", div_start_o);
        end
        @(posedge clk); #1;
        exp_q.push_back({32'd0, 32'd3});
        run_div("divu_9_3_after_done", EXE_DIVU_OP, 32'd9, 32'd3, 35, 0, 0);
    endtask

    task automatic test_whilo();
        exp_q.push_back({32'd2, 32'd2});
        run_div("divu_8_3_with_wb", EXE_DIVU_OP, 32'd8, 32'd3, 35, 1, 0);
        whilo_i = 1'b1; hi_i = 32'hAAAA_0000; lo_i = 32'h0000_5555;
        @(posedge clk); #1;
        whilo_i = 1'b0;
        n_checks++;
        if ({hi_o, lo_o} !== {32'hAAAA_0000, 32'h0000_5555}) begin
            n_fail++; $display("FAIL wb_write: got %h_%h want aaaa0000_00005555", hi_o, lo_o);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back({32'd2, 32'd3});
        run_div("b2b_first_divu_17_5", EXE_DIVU_OP, 32'd17, 32'd5, 35, 0, 0);
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
        run_div("b2b_second_div_m9_4", EXE_DIV_OP, 32'hFFFF_FFF7, 32'd4, 35, 0, 0);
    endtask

    task automatic test_reset_mid();
        op_i = EXE_DIVU_OP; reg1_i = 32'd100; reg2_i = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({div_start_o, stallreq_o, hi_o, lo_o} !== 66'h0) begin
            n_fail++; $display("FAIL reset_mid: got start=%b stall=%b hilo=%h_%h want all 0",
                               div_start_o, stallreq_o, hi_o, lo_o);
        end
        op_i = EXE_NOP_OP;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_zero();
        test_signed();
        test_flush();
        test_flush_at_ready();
        test_stall_done();
        test_whilo();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
